wasm_operand_stack: RTL and testbench
=====================================

# wasm_operand_stack

Parametrised operand stack for the WASM execution core, successor to the fixed-size pop-0..3/push-0..1 stack. Each accepted operation pops 0..POP_MAX entries and pushes 0..PUSH_MAX entries atomically in one clock. It also supports the branch-style "drop N beneath top K" compaction. Overflow and underflow are detected instead of saturated: the offending operation is rejected and the stack halts until software clears the error.

## Interface
- WIDTH, 32: bits per stack entry
- DEPTH, 16: entries of storage (power of two not required, ≥ 2)
- POP_MAX, 3: max entries popped per op; also pop_window lanes
- PUSH_MAX, 2: max entries pushed per op
- KEEP_MAX, 2: max entries preserved by DROPKEEP
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  operation request
- op_ready  out  1  block accepts an operation; op fires on op_valid & op_ready
- op_mode  in  1  0 = PUSHPOP, 1 = DROPKEEP
- pop_num  in  $clog2(POP_MAX+1)  entries to pop (PUSHPOP)
- push_num  in  $clog2(PUSH_MAX+1)  entries to push (PUSHPOP)
- push_data  in  PUSH_MAX*WIDTH  lane i at [i*WIDTH +: WIDTH]; lane push_num-1 becomes new top
- drop_num  in  $clog2(DEPTH+1)  entries removed beneath kept ones (DROPKEEP)
- keep_num  in  $clog2(KEEP_MAX+1)  top entries preserved (DROPKEEP)
- err_clr  in  1  clears error state
- pop_window  out  POP_MAX*WIDTH  lane 0 = top, lane j = j-th below top; lanes ≥ count read 0
- count  out  $clog2(DEPTH+1)  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- err_ovf  out  1  sticky overflow flag
- err_udf  out  1  sticky underflow flag

## Operation
- States: RUN, ERR. Reset → RUN. op_ready = (state == RUN), a function of state only, never of op_valid.
- PUSHPOP, legality: pop_num ≤ count and count − pop_num + push_num ≤ DEPTH. Pop is applied before push, so a full stack accepts pop 1/push 1.
- PUSHPOP, effect: remove top pop_num entries, then push lanes 0..push_num-1 in order. count ← count − pop_num + push_num.
- DROPKEEP, legality: keep_num + drop_num ≤ count.
- DROPKEEP, effect: top keep_num entries keep their order; the drop_num entries directly beneath them are removed; deeper entries shift up. count ← count − drop_num.
- Illegal op, underflow check first: pop_num > count (or keep+drop > count) sets err_udf; otherwise overflow sets err_ovf. Storage and count are unchanged and state → ERR.
- ERR: op_valid ignored. err_clr = 1 → RUN next edge, both flags cleared on that edge. err_clr in RUN has no effect.
- Storage invariant: every entry at index ≥ count holds 0. Vacated entries are zero-filled.
- pop_num = push_num = 0 (or drop_num = 0) is a legal no-op.

## Timing
- Reset (async, any time, including mid-op): count 0, storage 0, pop_window 0, full 0, empty 1, err_ovf 0, err_udf 0, state RUN, op_ready 1.
- Latency 1: an op accepted at edge k updates storage/count/full/empty/pop_window, all visible after edge k. Outputs are registered or decoded from registers only.
- Throughput: one op per cycle, back-to-back, with no bubble.
- Error flags and op_ready = 0 appear after the edge that sampled the illegal op. Recovery takes one edge with err_clr.
- err_clr is not an op. In ERR, an op_valid in the same cycle as err_clr is not accepted.

## Configuration
- WASM_STK_DROPKEEP_EN defined: DROPKEEP implemented as above.
- Not defined: drop_num/keep_num ports remain but are ignored. op_mode = 1 is accepted as a no-op (no state change, no error). The compaction datapath is not synthesised.

## Structure
- Package wasm_stack_pkg: op_mode enum (OP_PUSHPOP, OP_DROPKEEP), state enum (ST_RUN, ST_ERR), and the width helper localparams used by the ports.
- One sub-module, wasm_stack_shifter: combinational next-storage generator (pop shift, push insert, keep/drop compaction, zero fill). The top level holds the registers, count, legality check and FSM.

## Test plan
Bench config: WIDTH=32, DEPTH=8, POP_MAX=3, PUSH_MAX=2, KEEP_MAX=2.
- Reset, then push 2 {lane0=0xA, lane1=0xB} → count 2; pop_window lane0 = 0xB, lane1 = 0xA, lane2 = 0.
- Fill to count 8, then pop 1/push 1 of 0x55 → accepted; full stays 1; top = 0x55.
- Count 2, pop 3 → err_udf = 1, op_ready = 0, count still 2. Hold op_valid 3 cycles with no change. Pulse err_clr → flags 0, op_ready 1.
- Stack bottom→top {1,2,3,4,5}, DROPKEEP keep 2/drop 2 → stack {1,4,5}, count 3, window {5,4,1}. Repeat with the macro undefined → unchanged, no error.
- Back-to-back ops every cycle (push 2, pop 1, push 1, pop 2) → count 2, 1, 2, 0 after successive edges. Assert rst_n low mid-sequence → outputs at reset values immediately.

Source files
------------

// File: rtl/wasm_stack_pkg.sv
// Shared types and width helpers for the WASM operand stack.
// Define WASM_STK_DROPKEEP_EN to build the DROPKEEP compaction path.
package wasm_stack_pkg;

  typedef enum logic {
    OP_PUSHPOP  = 1'b0,
    OP_DROPKEEP = 1'b1
  } op_mode_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_e;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_POP_MAX  = 3;
  localparam int DEF_PUSH_MAX = 2;
  localparam int DEF_KEEP_MAX = 2;

  // Bits needed to hold a count in 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wasm_stack_shifter.sv
// Combinational next-storage generator: pop shift, push insert, keep/drop compaction, zero fill.
// Index 0 is the stack bottom; the DROPKEEP path exists only with WASM_STK_DROPKEEP_EN.
module wasm_stack_shifter
  import wasm_stack_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int POP_MAX  = DEF_POP_MAX,
  parameter int PUSH_MAX = DEF_PUSH_MAX,
  parameter int KEEP_MAX = DEF_KEEP_MAX
) (
  input  logic [DEPTH*WIDTH-1:0]      stk_i,
  input  logic [cnt_w(DEPTH)-1:0]     count_i,
  input  logic                        mode_i,
  input  logic [cnt_w(POP_MAX)-1:0]   pop_num_i,
  input  logic [cnt_w(PUSH_MAX)-1:0]  push_num_i,
  input  logic [PUSH_MAX*WIDTH-1:0]   push_data_i,
  input  logic [cnt_w(DEPTH)-1:0]     drop_num_i,
  input  logic [cnt_w(KEEP_MAX)-1:0]  keep_num_i,
  output logic [DEPTH*WIDTH-1:0]      stk_o
);

`ifndef WASM_STK_DROPKEEP_EN
  logic unused_dk;
  assign unused_dk = ^{drop_num_i, keep_num_i};
`endif

  always_comb begin
    int cnt;
    int base;
    int upto;
`ifdef WASM_STK_DROPKEEP_EN
    int lo;
    int src;
    lo  = 0;
    src = 0;
`endif
    stk_o = '0;
    cnt   = int'(count_i);
    base  = 0;
    upto  = 0;
    if (op_mode_e'(mode_i) == OP_PUSHPOP) begin
      base = cnt - int'(pop_num_i);
      upto = base + int'(push_num_i);
      for (int i = 0; i < DEPTH; i++) begin
        if (i < base) begin
          stk_o[i*WIDTH +: WIDTH] = stk_i[i*WIDTH +: WIDTH];
        end else if (i < upto && (i - base) < PUSH_MAX) begin
          stk_o[i*WIDTH +: WIDTH] = push_data_i[(i-base)*WIDTH +: WIDTH];
        end
      end
    end else begin
`ifdef WASM_STK_DROPKEEP_EN
      // Entries below the dropped band stay put; everything above slides down by drop_num.
      lo = cnt - int'(keep_num_i) - int'(drop_num_i);
      for (int i = 0; i < DEPTH; i++) begin
        src = i + int'(drop_num_i);
        if (i < lo) begin
          stk_o[i*WIDTH +: WIDTH] = stk_i[i*WIDTH +: WIDTH];
        end else if (src < DEPTH) begin
          stk_o[i*WIDTH +: WIDTH] = stk_i[src*WIDTH +: WIDTH];
        end
      end
`else
      stk_o = stk_i;
`endif
    end
  end

endmodule

// File: rtl/wasm_operand_stack.sv
// Operand stack: registers, occupancy, legality check and RUN/ERR FSM; 1-cycle op latency.
// op_ready depends on state only; illegal ops halt the stack until err_clr. Macro: WASM_STK_DROPKEEP_EN.
module wasm_operand_stack
  import wasm_stack_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int POP_MAX  = DEF_POP_MAX,
  parameter int PUSH_MAX = DEF_PUSH_MAX,
  parameter int KEEP_MAX = DEF_KEEP_MAX
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic                        op_mode,
  input  logic [cnt_w(POP_MAX)-1:0]   pop_num,
  input  logic [cnt_w(PUSH_MAX)-1:0]  push_num,
  input  logic [PUSH_MAX*WIDTH-1:0]   push_data,
  input  logic [cnt_w(DEPTH)-1:0]     drop_num,
  input  logic [cnt_w(KEEP_MAX)-1:0]  keep_num,
  input  logic                        err_clr,
  output logic [POP_MAX*WIDTH-1:0]    pop_window,
  output logic [cnt_w(DEPTH)-1:0]     count,
  output logic                        full,
  output logic                        empty,
  output logic                        err_ovf,
  output logic                        err_udf
);

  localparam int CW = cnt_w(DEPTH);

  state_e                   state_q, state_d;
  logic [DEPTH*WIDTH-1:0]   stk_q, stk_d, stk_nxt;
  logic [CW-1:0]            count_q, count_d;
  logic                     err_ovf_q, err_ovf_d;
  logic                     err_udf_q, err_udf_d;

  wasm_stack_shifter #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .POP_MAX  (POP_MAX),
    .PUSH_MAX (PUSH_MAX),
    .KEEP_MAX (KEEP_MAX)
  ) u_shifter (
    .stk_i       (stk_q),
    .count_i     (count_q),
    .mode_i      (op_mode),
    .pop_num_i   (pop_num),
    .push_num_i  (push_num),
    .push_data_i (push_data),
    .drop_num_i  (drop_num),
    .keep_num_i  (keep_num),
    .stk_o       (stk_nxt)
  );

`ifndef WASM_STK_DROPKEEP_EN
  logic unused_dk;
  assign unused_dk = ^{drop_num, keep_num};
`endif

  always_comb begin
    int cnt;
    int pop;
    int push;
`ifdef WASM_STK_DROPKEEP_EN
    int drop;
    int keep;
    drop = int'(drop_num);
    keep = int'(keep_num);
`endif
    state_d   = state_q;
    stk_d     = stk_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q;
    err_udf_d = err_udf_q;
    cnt       = int'(count_q);
    pop       = int'(pop_num);
    push      = int'(push_num);
    case (state_q)
      ST_RUN: begin
        if (op_valid) begin
          if (op_mode_e'(op_mode) == OP_PUSHPOP) begin
            if (pop > cnt) begin
              err_udf_d = 1'b1;
              state_d   = ST_ERR;
            end else if (cnt - pop + push > DEPTH) begin
              err_ovf_d = 1'b1;
              state_d   = ST_ERR;
            end else begin
              stk_d   = stk_nxt;
              count_d = CW'(cnt - pop + push);
            end
          end else begin
`ifdef WASM_STK_DROPKEEP_EN
            if (keep + drop > cnt) begin
              err_udf_d = 1'b1;
              state_d   = ST_ERR;
            end else begin
              stk_d   = stk_nxt;
              count_d = CW'(cnt - drop);
            end
`else
            // Compaction not built: DROPKEEP is a silent no-op.
            state_d = ST_RUN;
`endif
          end
        end
      end
      ST_ERR: begin
        if (err_clr) begin
          state_d   = ST_RUN;
          err_ovf_d = 1'b0;
          err_udf_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      stk_q     <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stk_q     <= stk_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  // Window lane j reads entry count-1-j; lanes past the bottom read zero.
  always_comb begin
    int idx;
    idx        = 0;
    pop_window = '0;
    for (int j = 0; j < POP_MAX; j++) begin
      idx = int'(count_q) - 1 - j;
      if (idx >= 0 && idx < DEPTH) begin
        pop_window[j*WIDTH +: WIDTH] = stk_q[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign op_ready = (state_q == ST_RUN);
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign err_ovf  = err_ovf_q;
  assign err_udf  = err_udf_q;

endmodule

// File: tb/tb_wasm_operand_stack.sv
// Directed, table-driven bench for wasm_operand_stack (DEPTH=8, POP_MAX=3, PUSH_MAX=2, KEEP_MAX=2).
module tb_wasm_operand_stack;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic        op_mode;
  logic [1:0]  pop_num;
  logic [1:0]  push_num;
  logic [63:0] push_data;
  logic [3:0]  drop_num;
  logic [1:0]  keep_num;
  logic        err_clr;
  logic [95:0] pop_window;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        err_ovf;
  logic        err_udf;

  int checks   = 0;
  int failures = 0;

  wasm_operand_stack #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .POP_MAX(3), .PUSH_MAX(2), .KEEP_MAX(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_mode(op_mode), .pop_num(pop_num), .push_num(push_num),
    .push_data(push_data), .drop_num(drop_num), .keep_num(keep_num),
    .err_clr(err_clr), .pop_window(pop_window), .count(count),
    .full(full), .empty(empty), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    int          pop;
    int          push;
    logic [31:0] d0;
    logic [31:0] d1;
    int          cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int c, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2,
                           input logic udf, input logic ovf, input logic rdy);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".w0"}, pop_window[31:0], w0);
    chk({tag, ".w1"}, pop_window[63:32], w1);
    chk({tag, ".w2"}, pop_window[95:64], w2);
    chk({tag, ".full"}, 32'(full), 32'(c == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(c == 0));
    chk({tag, ".udf"}, 32'(err_udf), 32'(udf));
    chk({tag, ".ovf"}, 32'(err_ovf), 32'(ovf));
    chk({tag, ".rdy"}, 32'(op_ready), 32'(rdy));
  endtask

  // Drives one op request and returns 1 time unit after the sampling edge.
  task automatic op(input logic mode, input int pop, input int push,
                    input logic [31:0] d0, input logic [31:0] d1,
                    input int drop, input int keep);
    op_valid  = 1'b1;
    op_mode   = mode;
    pop_num   = 2'(pop);
    push_num  = 2'(push);
    push_data = {d1, d0};
    drop_num  = 4'(drop);
    keep_num  = 2'(keep);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op_valid = 1'b0;
    op_mode  = 1'b0;
    pop_num  = '0;
    push_num = '0;
    drop_num = '0;
    keep_num = '0;
    err_clr  = 1'b0;
  endtask

  vec_t vt[8];

  initial begin
    push_data = '0;
    idle();
    rst_n = 1'b0;
    #3;
    chk_state("reset", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    #9 rst_n = 1'b1;

    vt[0] = '{1'b0, 0, 2, 32'hA,  32'hB, 2, 32'hB,  32'hA, 32'h0};
    vt[1] = '{1'b0, 0, 2, 32'h1,  32'h2, 4, 32'h2,  32'h1, 32'hB};
    vt[2] = '{1'b0, 0, 2, 32'h3,  32'h4, 6, 32'h4,  32'h3, 32'h2};
    vt[3] = '{1'b0, 0, 2, 32'h5,  32'h6, 8, 32'h6,  32'h5, 32'h4};
    vt[4] = '{1'b0, 1, 1, 32'h55, 32'h0, 8, 32'h55, 32'h5, 32'h4};
    vt[5] = '{1'b0, 3, 0, 32'h0,  32'h0, 5, 32'h3,  32'h2, 32'h1};
    vt[6] = '{1'b0, 3, 0, 32'h0,  32'h0, 2, 32'hB,  32'hA, 32'h0};
    vt[7] = '{1'b0, 0, 0, 32'h0,  32'h0, 2, 32'hB,  32'hA, 32'h0};
    for (int i = 0; i < 8; i++) begin
      op(vt[i].mode, vt[i].pop, vt[i].push, vt[i].d0, vt[i].d1, 0, 0);
      chk_state($sformatf("vec%0d", i), vt[i].cnt, vt[i].w0, vt[i].w1, vt[i].w2,
                1'b0, 1'b0, 1'b1);
    end

    // Underflow, then a held request while halted, then recovery.
    op(1'b0, 3, 0, 0, 0, 0, 0);
    chk_state("udf", 2, 32'hB, 32'hA, 0, 1'b1, 1'b0, 1'b0);
    op_mode  = 1'b0;
    pop_num  = 2'd0;
    push_num = 2'd1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_state($sformatf("udf_hold%0d", k), 2, 32'hB, 32'hA, 0, 1'b1, 1'b0, 1'b0);
    end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    chk_state("udf_clr", 2, 32'hB, 32'hA, 0, 1'b0, 1'b0, 1'b1);
    idle();

    // Overflow from a full stack.
    op(1'b0, 0, 2, 32'h10, 32'h11, 0, 0);
    op(1'b0, 0, 2, 32'h12, 32'h13, 0, 0);
    op(1'b0, 0, 2, 32'h14, 32'h15, 0, 0);
    chk_state("fill", 8, 32'h15, 32'h14, 32'h13, 1'b0, 1'b0, 1'b1);
    op(1'b0, 0, 1, 32'h77, 0, 0, 0);
    chk_state("ovf", 8, 32'h15, 32'h14, 32'h13, 1'b0, 1'b1, 1'b0);
    idle();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    chk_state("ovf_clr", 8, 32'h15, 32'h14, 32'h13, 1'b0, 1'b0, 1'b1);
    idle();
    op(1'b0, 3, 0, 0, 0, 0, 0);
    op(1'b0, 3, 0, 0, 0, 0, 0);
    op(1'b0, 2, 0, 0, 0, 0, 0);
    chk_state("drain", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);

    // DROPKEEP on bottom->top {1,2,3,4,5}.
    op(1'b0, 0, 2, 32'h1, 32'h2, 0, 0);
    op(1'b0, 0, 2, 32'h3, 32'h4, 0, 0);
    op(1'b0, 0, 1, 32'h5, 0, 0, 0);
    chk_state("dk_pre", 5, 32'h5, 32'h4, 32'h3, 1'b0, 1'b0, 1'b1);
    op(1'b1, 0, 0, 0, 0, 2, 2);
`ifdef WASM_STK_DROPKEEP_EN
    chk_state("dk", 3, 32'h5, 32'h4, 32'h1, 1'b0, 1'b0, 1'b1);
    op(1'b1, 0, 0, 0, 0, 2, 2);
    chk_state("dk_udf", 3, 32'h5, 32'h4, 32'h1, 1'b1, 1'b0, 1'b0);
    idle();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    chk_state("dk_clr", 3, 32'h5, 32'h4, 32'h1, 1'b0, 1'b0, 1'b1);
`else
    chk_state("dk_off", 5, 32'h5, 32'h4, 32'h3, 1'b0, 1'b0, 1'b1);
`endif
    // err_clr while running leaves everything alone.
    idle();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    chk({"clr_run", ".rdy"}, 32'(op_ready), 32'd1);
    chk({"clr_run", ".udf"}, 32'(err_udf), 32'd0);
    idle();

    // Back-to-back from a fresh reset, then async reset mid-sequence.
    rst_n = 1'b0;
    #2;
    chk_state("rst2", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    op(1'b0, 0, 2, 32'h7, 32'h8, 0, 0);
    chk_state("b2b0", 2, 32'h8, 32'h7, 0, 1'b0, 1'b0, 1'b1);
    op(1'b0, 1, 0, 0, 0, 0, 0);
    chk_state("b2b1", 1, 32'h7, 0, 0, 1'b0, 1'b0, 1'b1);
    op(1'b0, 0, 1, 32'h9, 0, 0, 0);
    chk_state("b2b2", 2, 32'h9, 32'h7, 0, 1'b0, 1'b0, 1'b1);
    op(1'b0, 2, 0, 0, 0, 0, 0);
    chk_state("b2b3", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    op(1'b0, 0, 2, 32'hC, 32'hD, 0, 0);
    chk_state("b2b4", 2, 32'hD, 32'hC, 0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_state("rst_mid", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_state("post_rst", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
